// File: rtl/cache_wb_core_if.sv
// cache_wb_core_if: CPU request/response, memory beat, flush and counter signals of the write-back cache
// slave modport: the cache (takes CPU requests, drives memory beats)
// master modport: the CPU/memory environment around the cache
interface cache_wb_core_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
);
  logic                     cpu_req_valid;
  logic                     cpu_req_ready;
  logic                     cpu_req_wr;
  logic [ADDRESS_WIDTH-1:0] cpu_req_addr;
  logic [DATA_WIDTH-1:0]    cpu_req_wdata;
  logic                     cpu_resp_valid;
  logic [DATA_WIDTH-1:0]    cpu_resp_rdata;
  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic                     mem_req_wr;
  logic [ADDRESS_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0]    mem_req_wdata;
  logic                     mem_resp_valid;
  logic [DATA_WIDTH-1:0]    mem_resp_rdata;
  logic                     flush_req;
  logic                     flush_busy;
  logic                     flush_done;
  logic [31:0]              hit_count;
  logic [31:0]              miss_count;
  modport slave (
    input  cpu_req_valid, cpu_req_wr, cpu_req_addr, cpu_req_wdata,
           mem_req_ready, mem_resp_valid, mem_resp_rdata, flush_req,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
           mem_req_valid, mem_req_wr, mem_req_addr, mem_req_wdata,
           flush_busy, flush_done, hit_count, miss_count
  );
  modport master (
    output cpu_req_valid, cpu_req_wr, cpu_req_addr, cpu_req_wdata,
           mem_req_ready, mem_resp_valid, mem_resp_rdata, flush_req,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
           mem_req_valid, mem_req_wr, mem_req_addr, mem_req_wdata,
           flush_busy, flush_done, hit_count, miss_count
  );
endinterface

// File: rtl/cache_wb_core.sv
// cache_wb_core: direct-mapped write-back/write-allocate cache with multi-word lines, flush walker and hit/miss counters
// clk/rst: clock and synchronous active-high reset
// bus (slave): CPU load/store port, word-wide memory beat port, flush control, counters
module cache_wb_core #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int INDEX_SIZE     = 6,
  parameter int WORDS_PER_LINE = 4
) (
  input logic             clk,
  input logic             rst,
  cache_wb_core_if.slave  bus
);
  localparam int WOFF  = $clog2(WORDS_PER_LINE);
  localparam int TAG_W = ADDRESS_WIDTH - INDEX_SIZE - WOFF;
  localparam int LINES = 1 << INDEX_SIZE;
  typedef enum logic [3:0] {
    IDLE, LOOKUP, RESPOND, WB, FILL_REQ, FILL_WAIT, FLUSH_SCAN, FLUSH_WB, FLUSH_DONE
  } state_t;
  state_t                   r_state;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic                     r_wr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [LINES-1:0]         r_valid;
  logic [LINES-1:0]         r_dirty;
  logic [TAG_W-1:0]         r_tag [LINES];
  logic [DATA_WIDTH-1:0]    r_data [LINES*WORDS_PER_LINE];
  logic [INDEX_SIZE-1:0]    r_fidx;
  logic [WOFF-1:0]          r_w;
  logic [31:0]              r_hits;
  logic [31:0]              r_misses;
  logic [TAG_W-1:0]         w_tag;
  logic [INDEX_SIZE-1:0]    w_aidx;
  logic [INDEX_SIZE-1:0]    w_idx;
  logic [WOFF-1:0]          w_woff;
  logic                     w_flush;
  logic                     w_hit;
  logic                     w_wbeat;
  always_comb begin
    w_tag   = r_addr[ADDRESS_WIDTH-1 -: TAG_W];
    w_aidx  = r_addr[WOFF +: INDEX_SIZE];
    w_woff  = r_addr[WOFF-1:0];
    w_flush = r_state inside {FLUSH_SCAN, FLUSH_WB, FLUSH_DONE};
    w_idx   = w_flush ? r_fidx : w_aidx;
    w_hit   = r_valid[w_aidx] && r_tag[w_aidx] == w_tag;
    w_wbeat = r_state inside {WB, FLUSH_WB};
  end
  // ready is masked by rst so every output reads 0 while reset is held
  assign bus.cpu_req_ready  = r_state == IDLE && !bus.flush_req && !rst;
  assign bus.cpu_resp_valid = r_state == RESPOND;
  assign bus.cpu_resp_rdata = (r_state == RESPOND && !r_wr) ? r_data[{w_aidx, w_woff}] : '0;
  assign bus.mem_req_valid  = w_wbeat || r_state == FILL_REQ;
  assign bus.mem_req_wr     = w_wbeat;
  // write beats target the resident (victim) tag, read beats the requested tag
  assign bus.mem_req_addr   = w_wbeat ? {r_tag[w_idx], w_idx, r_w} :
                              r_state == FILL_REQ ? {w_tag, w_aidx, r_w} : '0;
  assign bus.mem_req_wdata  = w_wbeat ? r_data[{w_idx, r_w}] : '0;
  assign bus.flush_busy     = w_flush;
  assign bus.flush_done     = r_state == FLUSH_DONE;
  assign bus.hit_count      = r_hits;
  assign bus.miss_count     = r_misses;
  // r_w wraps to 0 after the last beat of a line, so each burst starts from word 0
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_valid  <= '0;
      r_dirty  <= '0;
      r_hits   <= '0;
      r_misses <= '0;
      r_fidx   <= '0;
      r_w      <= '0;
      r_addr   <= '0;
      r_wr     <= 1'b0;
      r_wdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_w <= '0;
          if (bus.flush_req) begin
            r_fidx  <= '0;
            r_state <= FLUSH_SCAN;
          end else if (bus.cpu_req_valid) begin
            r_addr  <= bus.cpu_req_addr;
            r_wr    <= bus.cpu_req_wr;
            r_wdata <= bus.cpu_req_wdata;
            r_state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (w_hit) begin
            if (~&r_hits) r_hits <= r_hits + 1'b1;
            r_state <= RESPOND;
          end else begin
            if (~&r_misses) r_misses <= r_misses + 1'b1;
            r_state <= (r_valid[w_aidx] && r_dirty[w_aidx]) ? WB : FILL_REQ;
          end
        end
        WB: if (bus.mem_req_ready) begin
          r_w <= r_w + 1'b1;
          if (&r_w) r_state <= FILL_REQ;
        end
        FILL_REQ: if (bus.mem_req_ready) r_state <= FILL_WAIT;
        FILL_WAIT: if (bus.mem_resp_valid) begin
          r_data[{w_aidx, r_w}] <= bus.mem_resp_rdata;
          r_w <= r_w + 1'b1;
          if (&r_w) begin
            r_tag[w_aidx]   <= w_tag;
            r_valid[w_aidx] <= 1'b1;
            r_dirty[w_aidx] <= 1'b0;
            r_state         <= RESPOND;
          end else r_state <= FILL_REQ;
        end
        RESPOND: begin
          if (r_wr) begin
            r_data[{w_aidx, w_woff}] <= r_wdata;
            r_dirty[w_aidx]          <= 1'b1;
          end
          r_state <= IDLE;
        end
        FLUSH_SCAN: begin
          if (r_valid[r_fidx] && r_dirty[r_fidx]) r_state <= FLUSH_WB;
          else begin
            r_valid[r_fidx] <= 1'b0;
            r_dirty[r_fidx] <= 1'b0;
            r_fidx          <= r_fidx + 1'b1;
            r_state         <= &r_fidx ? FLUSH_DONE : FLUSH_SCAN;
          end
        end
        FLUSH_WB: if (bus.mem_req_ready) begin
          r_w <= r_w + 1'b1;
          if (&r_w) begin
            r_valid[r_fidx] <= 1'b0;
            r_dirty[r_fidx] <= 1'b0;
            r_fidx          <= r_fidx + 1'b1;
            r_state         <= &r_fidx ? FLUSH_DONE : FLUSH_SCAN;
          end
        end
        FLUSH_DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_wb_core.sv
// tb_cache_wb_core: directed and randomized checks of cache_wb_core against a flat-memory reference model
module tb_cache_wb_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cache_wb_core_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus ();
  cache_wb_core #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .INDEX_SIZE(6), .WORDS_PER_LINE(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  typedef struct packed {logic wr; logic [31:0] addr; logic [31:0] data;} beat_t;
  beat_t       log_q[$];
  beat_t       exp_q[$];
  logic [31:0] phys [logic [31:0]];
  logic [31:0] refm [logic [31:0]];
  bit          m_valid [64];
  bit          m_dirty [64];
  logic [23:0] m_tag [64];
  int          m_hits, m_misses;
  int          vectors = 0;
  int          errs = 0;
  bit          hold_ready = 1'b0;
  bit          hold_resp = 1'b0;
  bit          pend = 1'b0;
  int          pdly;
  logic [31:0] pdata;
  function automatic logic [31:0] init_word(logic [31:0] a);
    return (a[31:2] == 30'h40) ? 32'hA0 + {30'd0, a[1:0]} : (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction
  function automatic logic [31:0] pmem(logic [31:0] a);
    return phys.exists(a) ? phys[a] : init_word(a);
  endfunction
  function automatic logic [31:0] rmem(logic [31:0] a);
    return refm.exists(a) ? refm[a] : init_word(a);
  endfunction
  function automatic logic [31:0] line_addr(logic [23:0] t, int i, int w);
    logic [5:0] ii;
    logic [1:0] ww;
    ii = i[5:0];
    ww = w[1:0];
    return {t, ii, ww};
  endfunction
  task automatic chk(string tag, logic [71:0] obs, logic [71:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask
  // memory side: random ready, one read response after a random delay, stray responses while idle
  initial begin
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_rdata = '0;
      if (rst) begin
        pend = 1'b0;
        bus.mem_req_ready = 1'b0;
      end else begin
        if (pend) begin
          if (!hold_resp) begin
            if (pdly == 0) begin
              bus.mem_resp_valid = 1'b1;
              bus.mem_resp_rdata = pdata;
              pend = 1'b0;
            end else pdly--;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_rdata = $urandom;
        end
        bus.mem_req_ready = !hold_ready && ($urandom_range(0, 3) != 0);
        if (bus.mem_req_valid && bus.mem_req_ready) begin
          log_q.push_back('{bus.mem_req_wr, bus.mem_req_addr, bus.mem_req_wdata});
          if (bus.mem_req_wr) phys[bus.mem_req_addr] = bus.mem_req_wdata;
          else begin
            pend  = 1'b1;
            pdly  = $urandom_range(0, 2);
            pdata = pmem(bus.mem_req_addr);
          end
        end
      end
    end
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic model_op(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output bit hit, output logic [31:0] er);
    int idx;
    logic [23:0] tag;
    idx = int'(addr[7:2]);
    tag = addr[31:8];
    hit = m_valid[idx] && m_tag[idx] == tag;
    if (hit) m_hits++;
    else begin
      m_misses++;
      if (m_valid[idx] && m_dirty[idx])
        for (int w = 0; w < 4; w++)
          exp_q.push_back('{1'b1, line_addr(m_tag[idx], idx, w), rmem(line_addr(m_tag[idx], idx, w))});
      for (int w = 0; w < 4; w++) exp_q.push_back('{1'b0, line_addr(tag, idx, w), 32'd0});
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tag;
    end
    er = wr ? 32'd0 : rmem(addr);
    if (wr) begin
      refm[addr]   = wdata;
      m_dirty[idx] = 1'b1;
    end
  endtask
  task automatic model_flush();
    for (int i = 0; i < 64; i++) begin
      if (m_valid[i] && m_dirty[i])
        for (int w = 0; w < 4; w++)
          exp_q.push_back('{1'b1, line_addr(m_tag[i], i, w), rmem(line_addr(m_tag[i], i, w))});
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask
  // reset loses dirty data: the flat view reverts to what memory actually holds
  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hits   = 0;
    m_misses = 0;
    refm     = phys;
    log_q.delete();
    exp_q.delete();
  endtask
  task automatic check_log(string tag);
    chk({tag, "_beats"}, 72'(log_q.size()), 72'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) chk({tag, "_beat"}, 72'(log_q[i]), 72'(exp_q[i]));
    log_q.delete();
    exp_q.delete();
  endtask
  task automatic chk_counts(string tag);
    chk({tag, "_hits"}, 72'(bus.hit_count), 72'(m_hits));
    chk({tag, "_misses"}, 72'(bus.miss_count), 72'(m_misses));
  endtask
  task automatic wait_resp(input logic [31:0] er, input bit hit);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.cpu_resp_valid && lat < 1000);
    chk("resp_valid", 72'(bus.cpu_resp_valid), 72'(1));
    chk("resp_rdata", 72'(bus.cpu_resp_rdata), 72'(er));
    if (hit) chk("hit_latency", 72'(lat), 72'(2));
    @(negedge clk);
    chk("resp_pulse", 72'(bus.cpu_resp_valid), 72'(0));
  endtask
  task automatic cpu_op(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    bit hit;
    logic [31:0] er;
    int n;
    model_op(wr, addr, wdata, hit, er);
    @(negedge clk);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_wr    = wr;
    bus.cpu_req_addr  = addr;
    bus.cpu_req_wdata = wdata;
    #1;
    n = 0;
    while (!bus.cpu_req_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("accept", 72'(bus.cpu_req_ready), 72'(1));
    @(posedge clk);
    #1 bus.cpu_req_valid = 1'b0;
    wait_resp(er, hit);
    chk_counts("op");
    check_log("op");
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.cpu_req_valid = 1'b0;
    bus.flush_req     = 1'b0;
    @(negedge clk);
    chk("rst_ctl", 72'({bus.cpu_req_ready, bus.cpu_resp_valid, bus.mem_req_valid, bus.mem_req_wr,
                        bus.flush_busy, bus.flush_done}), 72'(0));
    chk("rst_data", 72'({bus.cpu_resp_rdata, bus.mem_req_wdata}), 72'(0));
    chk("rst_addr", 72'(bus.mem_req_addr), 72'(0));
    chk("rst_counters", 72'({bus.hit_count, bus.miss_count}), 72'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask
  task automatic do_flush();
    int n, done;
    model_flush();
    @(negedge clk);
    bus.flush_req = 1'b1;
    #1 chk("flush_ready", 72'(bus.cpu_req_ready), 72'(0));
    @(posedge clk);
    #1 bus.flush_req = 1'b0;
    @(negedge clk);
    chk("flush_busy", 72'(bus.flush_busy), 72'(1));
    done = 0;
    n = 0;
    while (bus.flush_busy && n < 3000) begin
      if (bus.flush_done) done++;
      @(negedge clk);
      n++;
    end
    chk("flush_done_cnt", 72'(done), 72'(1));
    chk("flush_end_busy", 72'(bus.flush_busy), 72'(0));
    chk_counts("flush");
    check_log("flush");
  endtask
  initial begin
    bit hit;
    logic [31:0] er;
    int n, done;
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_wr    = 1'b0;
    bus.cpu_req_addr  = '0;
    bus.cpu_req_wdata = '0;
    bus.flush_req     = 1'b0;
    do_reset();
    cpu_op(1'b0, 32'h100, 32'd0);
    cpu_op(1'b0, 32'h102, 32'd0);
    cpu_op(1'b1, 32'h101, 32'hDEADBEEF);
    cpu_op(1'b0, 32'h200, 32'd0);
    cpu_op(1'b1, 32'h200, 32'h0BADF00D);
    cpu_op(1'b1, 32'h514, 32'h13572468);
    do_flush();
    cpu_op(1'b0, 32'h101, 32'd0);
    // stall a victim writeback beat and watch it stay put
    cpu_op(1'b0, 32'h324, 32'd0);
    cpu_op(1'b1, 32'h325, 32'h12345678);
    hold_ready = 1'b1;
    fork
      cpu_op(1'b0, 32'h424, 32'd0);
      begin
        logic [31:0] a, d;
        int k;
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!(bus.mem_req_valid && bus.mem_req_wr) && k < 100);
        a = bus.mem_req_addr;
        d = bus.mem_req_wdata;
        chk("stall_addr", 72'(a), 72'(32'h324));
        repeat (10) begin
          @(negedge clk);
          chk("stall_hold", 72'({bus.mem_req_valid, bus.mem_req_wr, a, d, bus.cpu_req_ready, bus.cpu_resp_valid}),
              72'({1'b1, 1'b1, bus.mem_req_addr, bus.mem_req_wdata, 1'b0, 1'b0}));
        end
        hold_ready = 1'b0;
      end
    join
    // flush and CPU request in the same cycle: flush first, request after flush_done
    cpu_op(1'b1, 32'h640, 32'hCAFE0001);
    model_flush();
    model_op(1'b0, 32'h101, 32'd0, hit, er);
    @(negedge clk);
    bus.flush_req     = 1'b1;
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_wr    = 1'b0;
    bus.cpu_req_addr  = 32'h101;
    #1 chk("prio_ready", 72'(bus.cpu_req_ready), 72'(0));
    @(posedge clk);
    #1 bus.flush_req = 1'b0;
    done = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.flush_done) done++;
    end while (!bus.cpu_req_ready && n < 3000);
    chk("prio_after_done", 72'(done), 72'(1));
    @(posedge clk);
    #1 bus.cpu_req_valid = 1'b0;
    wait_resp(er, hit);
    chk_counts("prio");
    check_log("prio");
    // reset while a fill read is outstanding
    hold_resp = 1'b1;
    @(negedge clk);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_wr    = 1'b0;
    bus.cpu_req_addr  = 32'h7A8;
    #1 chk("fill_accept", 72'(bus.cpu_req_ready), 72'(1));
    @(posedge clk);
    #1 bus.cpu_req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (log_q.size() == 0 && n < 200);
    @(negedge clk);
    chk("fill_wait", 72'({bus.mem_req_valid, bus.cpu_resp_valid}), 72'(0));
    do_reset();
    hold_resp = 1'b0;
    cpu_op(1'b0, 32'h7A8, 32'd0);
    chk("rst_reread_miss", 72'(bus.miss_count), 72'(1));
    // randomized traffic over a few conflicting lines
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = {22'd0, 2'($urandom_range(0, 3)), 3'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 24) == 0) do_flush();
      else cpu_op(1'($urandom_range(0, 1)), a, $urandom);
    end
    do_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
